// File: rtl/aq_rst_req_ctrl_pkg.sv
// Shared encodings for the reset-request controller: FSM states and cause bit positions.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package aq_rst_req_ctrl_pkg;

    // FSM state encodings; values are kept stable for existing debug tooling
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ASSERT  = 2'b01;
    localparam logic [1:0] ST_HOLD    = 2'b10;
    localparam logic [1:0] ST_RELEASE = 2'b11;

    // Bit positions inside rst_cause
    localparam int CAUSE_SW  = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_HAD = 2;

    typedef logic [1:0] rst_state_t;
    typedef logic [2:0] rst_cause_t;

    // The request line is driven low only while asserting or stretching
    function automatic logic req_active(input rst_state_t st);
        return (st == ST_ASSERT) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/aq_rst_req_sync.sv
// Two-flop synchronizer for the reset-tree feedback, async reset to 0.
// Latency: 2 forever_cpuclk cycles from sync_in to sync_out.
// Backpressure: none; free-running sampler.
module aq_rst_req_sync (
    input  logic forever_cpuclk,
    input  logic pad_cpu_rst_b,
    input  logic sync_in,
    output logic sync_out
);

    logic [1:0] sync_ff;

    // Shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge forever_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], sync_in};
        end
    end

    assign sync_out = sync_ff[1];

endmodule

// File: rtl/aq_rst_req_ctrl.sv
// Merges SW/WDT/HAD reset requests into one registered, glitch-free active-low rst_req_b and records the cause.
// Latency: request in cycle 0 -> rst_req_b low in cycle 1; release HOLD_CYC cycles after the synchronized ack.
// Backpressure: requests arriving while a sequence is in flight are dropped. Optional ack timeout: AQ_RST_REQ_TMO_EN.
module aq_rst_req_ctrl
    import aq_rst_req_ctrl_pkg::*;
#(
    parameter int HOLD_CYC = 16,
    parameter int CNT_W    = 8,
    parameter int TMO_CYC  = 255
) (
    input  logic       forever_cpuclk,
    input  logic       pad_cpu_rst_b,
    input  logic       pad_yy_scan_mode,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    input  logic       had_rst_req,
    input  logic       core0_rst_b,
    input  logic       rst_cause_clr,
    output logic       rst_req_b,
    output logic       rst_busy,
    output logic [2:0] rst_cause,
    output logic       rst_cause_vld,
    output logic       rst_tmo_err
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
`ifdef AQ_RST_REQ_TMO_EN
    localparam logic [CNT_W-1:0] WAIT_STEP = CNT_ONE;
`else
    // Without the timeout the ack waits are unbounded and the counter idles there
    localparam logic [CNT_W-1:0] WAIT_STEP = '0;
`endif

    rst_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic           ack_b;
    logic           any_req;
    logic           accept;
    logic           tmo_hit;
    logic           rst_req_ff;
    logic           busy_ff;
    rst_cause_t     req_vec;
    rst_cause_t     cause_ff;
    logic           cause_vld_ff;

    aq_rst_req_sync u_ack_sync (
        .forever_cpuclk (forever_cpuclk),
        .pad_cpu_rst_b  (pad_cpu_rst_b),
        .sync_in        (core0_rst_b),
        .sync_out       (ack_b)
    );

    assign req_vec[CAUSE_SW]  = sw_rst_req;
    assign req_vec[CAUSE_WDT] = wdt_rst_req;
    assign req_vec[CAUSE_HAD] = had_rst_req;
    assign any_req = |req_vec;
    assign accept  = (state == ST_IDLE) && any_req && !pad_yy_scan_mode;

`ifdef AQ_RST_REQ_TMO_EN
    // Only meaningful while waiting in ASSERT (ack low) or RELEASE (ack high)
    assign tmo_hit = ((state == ST_ASSERT) && ack_b || (state == ST_RELEASE) && !ack_b)
                     && (cnt == TMO_LAST);
`else
    logic [CNT_W-1:0] tmo_cfg_unused;
    assign tmo_cfg_unused = TMO_LAST;
    assign tmo_hit        = 1'b0;
`endif

    // Next-state and counter logic; one counter serves both hold stretch and ack timeout
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end
            end
            ST_ASSERT: begin
                if (!ack_b) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + WAIT_STEP;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (ack_b || tmo_hit) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + WAIT_STEP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and flopped request/busy outputs (registered so the async reset input never sees a decode glitch)
    always_ff @(posedge forever_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rst_req_ff <= 1'b1;
            busy_ff    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rst_req_ff <= !req_active(state_nxt);
            busy_ff    <= (state_nxt != ST_IDLE);
        end
    end

    // Cause capture at acceptance; a capture beats a simultaneous clear
    always_ff @(posedge forever_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            cause_ff     <= '0;
            cause_vld_ff <= 1'b0;
        end else if (accept) begin
            cause_ff     <= req_vec;
            cause_vld_ff <= 1'b1;
        end else if (rst_cause_clr) begin
            cause_ff     <= '0;
            cause_vld_ff <= 1'b0;
        end
    end

`ifdef AQ_RST_REQ_TMO_EN
    logic tmo_err_ff;

    // Sticky ack-timeout flag, cleared together with the cause
    always_ff @(posedge forever_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            tmo_err_ff <= 1'b0;
        end else if (tmo_hit) begin
            tmo_err_ff <= 1'b1;
        end else if (rst_cause_clr) begin
            tmo_err_ff <= 1'b0;
        end
    end

    assign rst_tmo_err = tmo_err_ff;
`else
    assign rst_tmo_err = 1'b0;
`endif

    // Scan forces the request inactive right at the pin; the sequence itself keeps running
    assign rst_req_b     = pad_yy_scan_mode ? 1'b1 : rst_req_ff;
    assign rst_busy      = busy_ff;
    assign rst_cause     = cause_ff;
    assign rst_cause_vld = cause_vld_ff;

endmodule

// File: tb/tb_aq_rst_req_ctrl.sv
// Bench for aq_rst_req_ctrl with a modelled reset generator (async assert, 3-flop sync release).
// Latency: n/a.
// Backpressure: n/a.
module tb_aq_rst_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan = 1'b0;
    logic       sw = 1'b0;
    logic       wdt = 1'b0;
    logic       had = 1'b0;
    logic       clr = 1'b0;
    logic       core0;
    logic       rst_req_b;
    logic       rst_busy;
    logic [2:0] rst_cause;
    logic       rst_cause_vld;
    logic       rst_tmo_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        logic [2:0] cause;
        int         len;
    } exp_t;
    exp_t exp_q[$];

    aq_rst_req_ctrl #(.HOLD_CYC(16), .CNT_W(8), .TMO_CYC(8)) dut (
        .forever_cpuclk   (clk),
        .pad_cpu_rst_b    (rst_n),
        .pad_yy_scan_mode (scan),
        .sw_rst_req       (sw),
        .wdt_rst_req      (wdt),
        .had_rst_req      (had),
        .core0_rst_b      (core0),
        .rst_cause_clr    (clr),
        .rst_req_b        (rst_req_b),
        .rst_busy         (rst_busy),
        .rst_cause        (rst_cause),
        .rst_cause_vld    (rst_cause_vld),
        .rst_tmo_err      (rst_tmo_err)
    );

    always #5 clk = ~clk;

    // Reset generator model: asserts with rst_req_b, releases through 3 flops
    logic [2:0] gen_ff;
    logic       gen_stuck = 1'b0;
    always @(posedge clk or negedge rst_req_b or negedge rst_n) begin
        if (!rst_req_b || !rst_n) gen_ff <= 3'b000;
        else                      gen_ff <= {gen_ff[1:0], 1'b1};
    end
    assign core0 = gen_stuck | gen_ff[2];

    // Low-pulse monitor on rst_req_b
    int low_run = 0;
    int last_len = 0;
    int pulses = 0;
    always @(negedge clk) begin
        if (rst_req_b === 1'b0) begin
            low_run++;
        end else if (low_run != 0) begin
            last_len = low_run;
            pulses++;
            low_run = 0;
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int p0, input string nm);
        int n = 0;
        while (pulses == p0 && n < 300) begin
            tick();
            n++;
        end
        if (pulses == p0) begin
            chk_cnt++;
            $display("FAIL %s pulse_timeout pulses=%0d required>%0d", nm, pulses, p0);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (rst_busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (rst_busy !== 1'b0) $display("FAIL %s idle_timeout rst_busy=%b required 0", nm, rst_busy);
        else pass_cnt++;
    endtask

    task automatic score(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL %s scoreboard_empty", nm);
            return;
        end
        e = exp_q.pop_front();
        chk_cnt++;
        if (last_len !== e.len) $display("FAIL %s low_len got=%0d exp=%0d", nm, last_len, e.len);
        else pass_cnt++;
        chk_cnt++;
        if (rst_cause !== e.cause) $display("FAIL %s cause got=%b exp=%b", nm, rst_cause, e.cause);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        tick(2);
        chk_cnt++;
        if ({rst_req_b, rst_busy, rst_cause, rst_cause_vld, rst_tmo_err} !== 7'b1_0_000_0_0)
            $display("FAIL reset_vals got=%b exp=1000000",
                     {rst_req_b, rst_busy, rst_cause, rst_cause_vld, rst_tmo_err});
        else pass_cnt++;
        #3 rst_n = 1'b1;
        tick(10);
    endtask

    task automatic test_sw_basic();
        int p0 = pulses;
        exp_q.push_back('{3'b001, 19});
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk_cnt++;
        if (rst_req_b !== 1'b0 || rst_busy !== 1'b1)
            $display("FAIL sw_c1 req_b=%b busy=%b exp 0/1", rst_req_b, rst_busy);
        else pass_cnt++;
        chk_cnt++;
        if (rst_cause !== 3'b001 || rst_cause_vld !== 1'b1)
            $display("FAIL sw_cause cause=%b vld=%b exp 001/1", rst_cause, rst_cause_vld);
        else pass_cnt++;
        tick(18);
        chk_cnt++;
        if (rst_req_b !== 1'b0) $display("FAIL sw_c19 req_b=%b exp 0", rst_req_b);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (rst_req_b !== 1'b1 || rst_busy !== 1'b1)
            $display("FAIL sw_c20 req_b=%b busy=%b exp 1/1", rst_req_b, rst_busy);
        else pass_cnt++;
        tick(5);
        chk_cnt++;
        if (rst_busy !== 1'b1) $display("FAIL sw_c25 busy=%b exp 1", rst_busy);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (rst_busy !== 1'b0) $display("FAIL sw_c26 busy=%b exp 0", rst_busy);
        else pass_cnt++;
        wait_pulse(p0, "sw_basic");
        score("sw_basic");
        tick(3);
    endtask

    task automatic test_simultaneous();
        int p0 = pulses;
        exp_q.push_back('{3'b110, 19});
        wdt = 1'b1;
        had = 1'b1;
        tick();
        wdt = 1'b0;
        had = 1'b0;
        wait_pulse(p0, "simul");
        score("simul");
        chk_cnt++;
        if (rst_cause_vld !== 1'b1) $display("FAIL simul_vld got=%b exp 1", rst_cause_vld);
        else pass_cnt++;
        wait_idle("simul");
        tick(5);
        chk_cnt++;
        if (pulses !== p0 + 1) $display("FAIL simul_single pulses=%0d exp=%0d", pulses, p0 + 1);
        else pass_cnt++;
    endtask

    task automatic test_busy_drop();
        int p0 = pulses;
        exp_q.push_back('{3'b010, 19});
        wdt = 1'b1;
        tick();
        wdt = 1'b0;
        tick(7);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk_cnt++;
        if (rst_cause !== 3'b010) $display("FAIL drop_cause got=%b exp 010", rst_cause);
        else pass_cnt++;
        wait_pulse(p0, "busy_drop");
        score("busy_drop");
        wait_idle("busy_drop");
        tick(5);
        chk_cnt++;
        if (pulses !== p0 + 1 || rst_busy !== 1'b0)
            $display("FAIL drop_no_retrigger pulses=%0d busy=%b exp=%0d/0", pulses, rst_busy, p0 + 1);
        else pass_cnt++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_cnt++;
        if (rst_cause !== 3'b000 || rst_cause_vld !== 1'b0)
            $display("FAIL clr cause=%b vld=%b exp 000/0", rst_cause, rst_cause_vld);
        else pass_cnt++;
    endtask

    task automatic test_clr_collision();
        int p0 = pulses;
        exp_q.push_back('{3'b001, 19});
        sw = 1'b1;
        clr = 1'b1;
        tick();
        sw = 1'b0;
        clr = 1'b0;
        chk_cnt++;
        if (rst_cause !== 3'b001 || rst_cause_vld !== 1'b1)
            $display("FAIL clr_collide cause=%b vld=%b exp 001/1", rst_cause, rst_cause_vld);
        else pass_cnt++;
        wait_pulse(p0, "clr_collide");
        score("clr_collide");
        wait_idle("clr_collide");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(2);
    endtask

    task automatic test_scan();
        int p0 = pulses;
        int bad = 0;
        scan = 1'b1;
        wdt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_cnt++;
            if (rst_req_b !== 1'b1 || rst_busy !== 1'b0) begin
                $display("FAIL scan_block cyc=%0d req_b=%b busy=%b exp 1/0", i, rst_req_b, rst_busy);
                bad++;
            end else pass_cnt++;
        end
        wdt = 1'b0;
        tick();
        scan = 1'b0;
        tick(3);
        chk_cnt++;
        if (pulses !== p0 || rst_busy !== 1'b0 || rst_cause_vld !== 1'b0)
            $display("FAIL scan_after pulses=%0d busy=%b vld=%b exp=%0d/0/0",
                     pulses, rst_busy, rst_cause_vld, p0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        tick(7);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({rst_req_b, rst_busy, rst_cause, rst_cause_vld} !== 6'b1_0_000_0)
            $display("FAIL rst_mid_async got=%b exp 100000", {rst_req_b, rst_busy, rst_cause, rst_cause_vld});
        else pass_cnt++;
        #2 rst_n = 1'b1;
        tick();
        chk_cnt++;
        if ({rst_req_b, rst_busy, rst_cause, rst_cause_vld} !== 6'b1_0_000_0)
            $display("FAIL rst_mid_next got=%b exp 100000", {rst_req_b, rst_busy, rst_cause, rst_cause_vld});
        else pass_cnt++;
        tick(10);
    endtask

`ifdef AQ_RST_REQ_TMO_EN
    task automatic test_timeout();
        gen_stuck = 1'b1;
        tick(2);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk_cnt++;
        if (rst_req_b !== 1'b0) $display("FAIL tmo_c1 req_b=%b exp 0", rst_req_b);
        else pass_cnt++;
        tick(7);
        chk_cnt++;
        if (rst_req_b !== 1'b0 || rst_busy !== 1'b1 || rst_tmo_err !== 1'b0)
            $display("FAIL tmo_c8 req_b=%b busy=%b err=%b exp 0/1/0", rst_req_b, rst_busy, rst_tmo_err);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (rst_req_b !== 1'b1 || rst_busy !== 1'b0 || rst_tmo_err !== 1'b1)
            $display("FAIL tmo_c9 req_b=%b busy=%b err=%b exp 1/0/1", rst_req_b, rst_busy, rst_tmo_err);
        else pass_cnt++;
        tick(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_cnt++;
        if (rst_tmo_err !== 1'b0 || rst_cause_vld !== 1'b0)
            $display("FAIL tmo_clr err=%b vld=%b exp 0/0", rst_tmo_err, rst_cause_vld);
        else pass_cnt++;
        gen_stuck = 1'b0;
        tick(3);
    endtask
`else
    task automatic test_timeout();
        chk_cnt++;
        if (rst_tmo_err !== 1'b0) $display("FAIL tmo_tied err=%b exp 0", rst_tmo_err);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_sw_basic();
        test_simultaneous();
        test_busy_drop();
        test_clr_collision();
        test_scan();
        test_reset_mid();
        test_timeout();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover size=%0d exp 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout passed=%0d total=%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
